div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  start request, sampled on rising clk.
REQ-005 completed  output  1  high when quo/res hold a valid result.
REQ-006 is_signed  input  1  1 = two's-complement division; 0 = unsigned division.
REQ-007 src  input  32  dividend.
REQ-008 sink  input  32  divisor.
REQ-009 quo  output  32  quotient.
REQ-010 res  output  32  remainder.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 Start: enable=1 at a rising edge in IDLE or DONE SHALL latch src, sink and is_signed, clear completed, and enter BUSY.
REQ-013 Operands SHALL be ignored after the start edge; changes to src, sink or is_signed during BUSY SHALL NOT affect the result.
REQ-014 enable SHALL be ignored while in BUSY; the operation in progress continues unaffected.
REQ-015 BUSY SHALL perform a radix-2 restoring (or non-restoring) long division on magnitudes, one quotient bit per cycle, for exactly 32 cycles.
REQ-016 Latency: completed SHALL rise and quo/res SHALL be valid immediately after the 33rd rising edge, counting the start edge as edge 1; state then becomes DONE.
REQ-017 In DONE, completed, quo and res SHALL hold steady until the next start, regardless of enable=0 or input changes.
REQ-018 During BUSY, quo and res SHALL keep their previous values or show intermediate values; they are valid only while completed=1.
REQ-019 Unsigned mode: quo = floor(src/sink) and res = src mod sink, with all 32 bits treated as magnitude.
REQ-020 Signed mode: the quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; |res| < |sink|.
REQ-021 Signed mode: operands SHALL be converted to 32-bit magnitudes before iterating and the results negated afterwards as needed; the sign fixup SHALL fit within the 33-cycle latency.
REQ-022 Divide by zero (sink=0), either mode: quo SHALL be 32'hFFFFFFFF and res SHALL be src; latency is unchanged.
REQ-023 Signed overflow (src=32'h80000000, sink=32'hFFFFFFFF, is_signed=1): quo SHALL be 32'h80000000 and res SHALL be 0.
REQ-024 A start taken in DONE on the same edge that would otherwise hold SHALL begin a new operation; completed SHALL be 0 after that edge.

Reset
REQ-025 rstn=0 SHALL, asynchronously: force state to IDLE; set completed=0, quo=0 and res=0; clear all internal registers.
REQ-026 Reset asserted during BUSY SHALL abort the operation with no result produced; after release, the block waits in IDLE for enable.
REQ-027 The first rising edge after rstn deasserts SHALL be able to accept a start.

Verification
REQ-028 Unsigned: src=100, sink=7, is_signed=0, one-cycle enable pulse -> after 33 edges completed=1, quo=14, res=2; completed=0 after 32 edges.
REQ-029 Signed: src=-7 (32'hFFFFFFF9), sink=2, is_signed=1 -> quo=-3 (32'hFFFFFFFD), res=-1 (32'hFFFFFFFF).
REQ-030 Unsigned large: src=32'hFFFFFFFF, sink=32'h00000010 -> quo=32'h0FFFFFFF, res=32'hF; the same operands with is_signed=1 -> quo=0, res=32'hFFFFFFFF.
REQ-031 Divide by zero: src=1234, sink=0, in both modes -> quo=32'hFFFFFFFF, res=1234 after 33 edges.
REQ-032 Signed overflow case per REQ-023, followed by a random stream of 1000 operands in each mode compared against a golden model (/ and %), with operands changed mid-BUSY and enable pulsed mid-BUSY -> results unaffected.
REQ-033 Assert rstn=0 at cycle 10 of BUSY -> completed=0, quo=0 and res=0 immediately; a new start after release completes correctly in 33 edges.

Source files
------------

// File: rtl/div_unit.sv
// 32-bit radix-2 restoring divider, signed or unsigned.
// Start edge latches operands; result valid after the 33rd edge.
module div_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        is_signed,
  input  logic [31:0] src,
  input  logic [31:0] sink,
  output logic        completed,
  output logic [31:0] quo,
  output logic [31:0] res
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] src_q, src_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        ge;
  logic [31:0] q_nxt;
  logic [31:0] r_nxt;

  // One restoring step: a_q shifts dividend bits out and quotient bits in.
  always_comb begin
    rem_sh = {rem_q, a_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, b_q};
    ge     = ~diff[33];
    q_nxt  = {a_q[30:0], ge};
    r_nxt  = ge ? diff[31:0] : rem_sh[31:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    src_d   = src_q;
    quo_d   = quo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          state_d = BUSY;
          src_d   = src;
          a_d     = (is_signed && src[31]) ? -src : src;
          b_d     = (is_signed && sink[31]) ? -sink : sink;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = is_signed & (src[31] ^ sink[31]);
          rneg_d  = is_signed & src[31];
          dz_d    = (sink == '0);
          done_d  = 1'b0;
        end
      end
      BUSY: begin
        a_d   = q_nxt;
        rem_d = r_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          done_d  = 1'b1;
          // Sign fixup folds into the final iteration edge.
          quo_d   = dz_q ? '1 : (qneg_q ? -q_nxt : q_nxt);
          res_d   = dz_q ? src_q : (rneg_q ? -r_nxt : r_nxt);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      src_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      src_q   <= src_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign completed = done_q;
  assign quo       = quo_q;
  assign res       = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against a plain-arithmetic model.
// Covers directed corners, mid-BUSY disturbance and reset abort.
module tb_div_unit;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        is_signed;
  logic [31:0] src;
  logic [31:0] sink;
  logic        completed;
  logic [31:0] quo;
  logic [31:0] res;

  int n_run;
  int n_fail;

  div_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .is_signed (is_signed),
    .src       (src),
    .sink      (sink),
    .completed (completed),
    .quo       (quo),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] s,
                                input logic [31:0] d,
                                input logic sg,
                                output logic [31:0] q,
                                output logic [31:0] r);
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = s;
    end else if (sg && s == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sg) begin
      q = 32'($signed(s) / $signed(d));
      r = 32'($signed(s) % $signed(d));
    end else begin
      q = s / d;
      r = s % d;
    end
  endfunction

  // Call away from a rising edge; the next rising edge is the start edge.
  task automatic do_op(input logic [31:0] s,
                       input logic [31:0] d,
                       input logic sg,
                       input bit disturb);
    logic [31:0] eq, er;
    model(s, d, sg, eq, er);
    src       = s;
    sink      = d;
    is_signed = sg;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    chk("start_clr", {31'd0, completed}, 32'd0);
    enable = 1'b0;
    for (int i = 2; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (disturb) begin
        src       = $urandom;
        sink      = $urandom;
        is_signed = 1'($urandom);
        enable    = (i == 10 || i == 20) ? 1'b1 : 1'b0;
      end
    end
    enable = 1'b0;
    chk("busy_e32", {31'd0, completed}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_e33", {31'd0, completed}, 32'd1);
    chk("quo", quo, eq);
    chk("res", res, er);
  endtask

  task automatic hold_chk(input int cycles);
    logic [31:0] hq, hr;
    hq = quo;
    hr = res;
    for (int i = 0; i < cycles; i++) begin
      src  = $urandom;
      sink = $urandom;
      @(posedge clk);
      #1;
      chk("hold_cmp", {31'd0, completed}, 32'd1);
      chk("hold_quo", quo, hq);
      chk("hold_res", res, hr);
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    enable    = 1'b0;
    is_signed = 1'b0;
    src       = '0;
    sink      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmp", {31'd0, completed}, 32'd0);
    chk("rst_quo", quo, 32'd0);
    chk("rst_res", res, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    // First edge after release is the start edge.
    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    chk("u100_7_q", quo, 32'd14);
    chk("u100_7_r", res, 32'd2);
    hold_chk(3);
    @(negedge clk);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("s-7_2_q", quo, 32'hFFFF_FFFD);
    chk("s-7_2_r", res, 32'hFFFF_FFFF);
    // Back-to-back start straight out of DONE.
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    chk("ubig_q", quo, 32'h0FFF_FFFF);
    chk("ubig_r", res, 32'h0000_000F);
    do_op(32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0);
    chk("sbig_q", quo, 32'd0);
    chk("sbig_r", res, 32'hFFFF_FFFF);
    do_op(32'd1234, 32'd0, 1'b0, 1'b0);
    chk("udz_q", quo, 32'hFFFF_FFFF);
    chk("udz_r", res, 32'd1234);
    do_op(32'd1234, 32'd0, 1'b1, 1'b0);
    chk("sdz_q", quo, 32'hFFFF_FFFF);
    chk("sdz_r", res, 32'd1234);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("ovf_q", quo, 32'h8000_0000);
    chk("ovf_r", res, 32'd0);
    hold_chk(2);
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        logic [31:0] s, d;
        s = $urandom;
        d = $urandom;
        case (k % 8)
          0: d = 32'd0;
          1: d = 32'($urandom_range(1, 16));
          2: d = -32'($urandom_range(1, 16));
          3: s = 32'h8000_0000;
          default: ;
        endcase
        @(negedge clk);
        do_op(s, d, m[0], 1'b1);
      end
    end
    // Abort at cycle 10 of BUSY.
    @(negedge clk);
    src       = 32'd999;
    sink      = 32'd3;
    is_signed = 1'b0;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_cmp", {31'd0, completed}, 32'd0);
    chk("abort_quo", quo, 32'd0);
    chk("abort_res", res, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", {31'd0, completed}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    do_op(32'd1000, 32'd9, 1'b0, 1'b0);
    chk("post_q", quo, 32'd111);
    chk("post_r", res, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
